// File: rtl/snn_ctrl.sv
// rtl/snn_ctrl.sv - UART-to-SNN-core sequencer: unpacks a binary image into
// the core input RAM, runs inference and returns the digit as ASCII.
module snn_ctrl #(
  parameter int NUM_PIX = 784,
  parameter int ADDR_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wdata,
  output logic              core_start,
  input  logic              core_done,
  input  logic [3:0]        core_digit,
  output logic [7:0]        led
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIX - 1);

  typedef enum logic [2:0] {RECV, UNPACK, START, WAIT, SEND} state_e;

  state_e              state_q, state_d;
  logic [7:0]          shift_q, shift_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [3:0]          digit_q, digit_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                ovr_q, ovr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RECV;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      pix_cnt_q <= '0;
      digit_q   <= '0;
      tx_data_q <= '0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      digit_q   <= digit_d;
      tx_data_q <= tx_data_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    digit_d    = digit_q;
    tx_data_d  = tx_data_q;
    // A byte arriving while busy is dropped; the flag is sticky until reset.
    ovr_d      = ovr_q | (rx_rdy && (state_q != RECV));
    ram_we     = 1'b0;
    core_start = 1'b0;
    tx_start   = 1'b0;

    case (state_q)
      RECV: begin
        if (rx_rdy) begin
          shift_d   = rx_data;
          bit_cnt_d = '0;
          state_d   = UNPACK;
        end
      end
      UNPACK: begin
        ram_we    = 1'b1;
        shift_d   = {1'b0, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        // Saturate on the last pixel so the counter never leaves the image.
        if (pix_cnt_q != LAST_PIX) pix_cnt_d = pix_cnt_q + 1'b1;
        if (bit_cnt_q == 3'd7) begin
          state_d = (pix_cnt_q == LAST_PIX) ? START : RECV;
        end
      end
      START: begin
        core_start = 1'b1;
        pix_cnt_d  = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          digit_d   = core_digit;
          tx_data_d = (core_digit <= 4'd9) ? (8'h30 + {4'h0, core_digit}) : 8'h3F;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = RECV;
        end
      end
      default: state_d = RECV;
    endcase
  end

  assign tx_data   = tx_data_q;
  assign ram_addr  = pix_cnt_q;
  assign ram_wdata = shift_q[0];
  assign led       = {ovr_q, 3'b000, digit_q};

endmodule

// File: tb/tb_snn_ctrl.sv
// tb/tb_snn_ctrl.sv - directed self-checking bench for snn_ctrl.
module tb_snn_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_busy = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       ram_we;
  logic [9:0] ram_addr;
  logic       ram_wdata;
  logic       core_start;
  logic       core_done = 1'b0;
  logic [3:0] core_digit = 4'h0;
  logic [7:0] led;

  int n_cmp = 0;
  int n_err = 0;

  snn_ctrl #(.NUM_PIX(784), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_rdy(rx_rdy), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .core_start(core_start), .core_done(core_done), .core_digit(core_digit),
    .led(led)
  );

  always #10 clk = ~clk;

  // mode 1: extra rx_rdy during unpack; mode 2: core_done pulse during unpack
  task automatic send_byte(input logic [7:0] b, input logic [9:0] base, input int mode);
    rx_data = b;
    rx_rdy  = 1'b1;
    @(negedge clk);
    rx_rdy  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (ram_we !== 1'b1 || ram_addr !== base + 10'(k) || ram_wdata !== b[k]) begin
        n_err++;
        $display("FAIL ram_write: got we=%b addr=%0d data=%b, expected we=1 addr=%0d data=%b",
                 ram_we, ram_addr, ram_wdata, base + 10'(k), b[k]);
      end
      if (mode == 1 && k == 2) begin
        rx_rdy  = 1'b1;
        rx_data = 8'hFF;
      end else if (mode == 2 && k == 4) begin
        core_done  = 1'b1;
        core_digit = 4'h5;
      end else begin
        rx_rdy    = 1'b0;
        core_done = 1'b0;
      end
      @(negedge clk);
    end
    rx_rdy    = 1'b0;
    core_done = 1'b0;
  endtask

  task automatic send_image(input logic [7:0] pat, input bit vary, input int nbytes,
                            input int mode_byte, input int mode);
    logic [7:0] b;
    for (int i = 0; i < nbytes; i++) begin
      b = vary ? (pat ^ 8'(i)) : pat;
      send_byte(b, 10'(i * 8), (i == mode_byte) ? mode : 0);
      if (i < 97) begin
        n_cmp++;
        if (ram_we !== 1'b0 || core_start !== 1'b0) begin
          n_err++;
          $display("FAIL byte_gap: got we=%b core_start=%b, expected 0 0", ram_we, core_start);
        end
      end
    end
    if (nbytes == 98) begin
      n_cmp++;
      if (core_start !== 1'b1 || ram_we !== 1'b0) begin
        n_err++;
        $display("FAIL core_start_pulse: got core_start=%b we=%b, expected 1 0", core_start, ram_we);
      end
      @(negedge clk);
      n_cmp++;
      if (core_start !== 1'b0 || ram_we !== 1'b0) begin
        n_err++;
        $display("FAIL core_start_width: got core_start=%b we=%b, expected 0 0", core_start, ram_we);
      end
    end
  endtask

  task automatic do_result(input logic [3:0] d, input int busy_cycles,
                           input logic [7:0] exp_tx, input logic [7:0] exp_led);
    tx_busy    = (busy_cycles > 0);
    core_digit = d;
    core_done  = 1'b1;
    @(negedge clk);
    core_done  = 1'b0;
    core_digit = 4'h0;
    for (int c = 0; c < busy_cycles; c++) begin
      n_cmp++;
      if (tx_start !== 1'b0) begin
        n_err++;
        $display("FAIL tx_start_busy: got %b at busy cycle %0d, expected 0", tx_start, c);
      end
      @(negedge clk);
    end
    tx_busy = 1'b0;
    #1;
    n_cmp++;
    if (tx_start !== 1'b1 || tx_data !== exp_tx || led !== exp_led) begin
      n_err++;
      $display("FAIL result_tx: got tx_start=%b tx_data=%h led=%h, expected 1 %h %h",
               tx_start, tx_data, led, exp_tx, exp_led);
    end
    @(negedge clk);
    n_cmp++;
    if (tx_start !== 1'b0 || tx_data !== exp_tx || led !== exp_led) begin
      n_err++;
      $display("FAIL result_hold: got tx_start=%b tx_data=%h led=%h, expected 0 %h %h",
               tx_start, tx_data, led, exp_tx, exp_led);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00 || ram_we !== 1'b0 || ram_addr !== 10'd0 ||
        ram_wdata !== 1'b0 || core_start !== 1'b0 || led !== 8'h00) begin
      n_err++;
      $display("FAIL reset_values: got tx_start=%b tx_data=%h we=%b addr=%0d wdata=%b cs=%b led=%h, expected all 0",
               tx_start, tx_data, ram_we, ram_addr, ram_wdata, core_start, led);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_image_a5;
    send_image(8'hA5, 1'b0, 98, -1, 0);
    do_result(4'd7, 0, 8'h37, 8'h07);
  endtask

  task automatic test_busy_result;
    send_image(8'h3C, 1'b1, 98, -1, 0);
    do_result(4'd12, 50, 8'h3F, 8'h0C);
  endtask

  task automatic test_overrun;
    send_image(8'h96, 1'b1, 98, 2, 1);
    do_result(4'd3, 0, 8'h33, 8'h83);
  endtask

  task automatic test_reset_mid;
    send_image(8'h5A, 1'b1, 40, -1, 0);
    rx_data = 8'hFF;
    rx_rdy  = 1'b1;
    @(negedge clk);
    rx_rdy  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00 || ram_we !== 1'b0 || ram_addr !== 10'd0 ||
        ram_wdata !== 1'b0 || core_start !== 1'b0 || led !== 8'h00) begin
      n_err++;
      $display("FAIL reset_mid: got tx_start=%b tx_data=%h we=%b addr=%0d wdata=%b cs=%b led=%h, expected all 0",
               tx_start, tx_data, ram_we, ram_addr, ram_wdata, core_start, led);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_image(8'hC3, 1'b1, 98, -1, 0);
    do_result(4'd9, 0, 8'h39, 8'h09);
  endtask

  task automatic test_core_done_ignored;
    core_digit = 4'h2;
    core_done  = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (core_start !== 1'b0 || tx_start !== 1'b0 || led !== 8'h09) begin
        n_err++;
        $display("FAIL done_in_recv: got cs=%b tx_start=%b led=%h, expected 0 0 09",
                 core_start, tx_start, led);
      end
    end
    core_done = 1'b0;
    send_byte(8'h81, 10'd0, 2);
    n_cmp++;
    if (core_start !== 1'b0 || tx_start !== 1'b0 || led !== 8'h09 || ram_we !== 1'b0) begin
      n_err++;
      $display("FAIL done_in_unpack: got cs=%b tx_start=%b led=%h we=%b, expected 0 0 09 0",
               core_start, tx_start, led, ram_we);
    end
    send_byte(8'h7E, 10'd8, 0);
  endtask

  initial begin
    test_reset();
    test_image_a5();
    test_busy_result();
    test_overrun();
    test_reset_mid();
    test_core_done_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
